reg_file_2r1w: RTL and testbench
================================

Name: reg_file_2r1w

Overview:
- 32-entry x 32-bit general-purpose register file for the 5-stage pipeline, with two read ports and one write port.
- The write port is driven by the WB stage. The read ports feed ID-stage operand latches.
- The block owns register storage and write-enable decode.
- Each read port is a bit-sliced array of the existing 32:1 single-bit mux, with one mux per data bit, selecting across all registers.
- Internal write-through bypass lets a WB write and an ID read of the same register in the same cycle return the new value.

Parameters:
- WIDTH, 32, data width of each register. Equals the number of 32:1 bit-slice muxes per read port.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero: writes are ignored and reads return 0.

Ports:
- CLK  input  1  Single clock; all state updates on the rising edge.
- RST  input  1  Synchronous reset, active-high.
- WE  input  1  Write enable from WB.
- WADDR  input  5  Write register index.
- WDATA  input  WIDTH  Write data.
- RADDR1  input  5  Read port 1 register index.
- RADDR2  input  5  Read port 2 register index.
- RDATA1  output  WIDTH  Read port 1 data, combinational.
- RDATA2  output  WIDTH  Read port 2 data, combinational.

Behaviour:
- Interface:
  - One clock, CLK.
  - Reset RST is synchronous and active-high. It is sampled only on the rising edge of CLK.
- Storage:
  - 32 registers, REG[0..31], each WIDTH bits.
- Reset:
  - On a rising edge with RST=1, all 32 registers become 0.
  - RST has priority over WE; a write presented in the reset cycle is discarded.
  - After that edge, RDATA1 and RDATA2 read 0 for every address.
- Write:
  - On a rising edge with RST=0 and WE=1, REG[WADDR] <= WDATA.
  - If ZERO_REG=1 and WADDR=0, no register changes.
  - WE=0 leaves all registers unchanged.
  - Only one register is written per cycle.
- Read:
  - Fully combinational, zero-cycle latency. RDATAn[b] = REG[RADDRn][b] via one 32:1 mux per bit b, select = RADDRn.
  - With ZERO_REG=1, RADDRn=0 returns 0 regardless of storage contents.
- Bypass (write-before-read):
  - If RST=0, WE=1, WADDR=RADDRn, and WADDR is not 0 (when ZERO_REG=1), then RDATAn = WDATA in the same cycle.
  - Ports 1 and 2 bypass independently; both may bypass simultaneously on the same address.
  - While RST=1, bypass is disabled and RDATAn shows stored contents.
- Boundaries:
  - RADDR1 = RADDR2 is legal; both ports return identical data.
  - Index 31 is a normal register; there is no wrap or aliasing.
  - A write to register 0 with ZERO_REG=1 produces neither a bypass nor a storage change.
  - X on WADDR while WE=0 has no effect on state.
- Timing:
  - Read path = bypass compare + 5-level mux tree (4-level 16:1 + final 2:1).
  - No registered outputs.

Decomposition:
- Shared include file (regfile_defs.vh):
  - REG_COUNT = 32, REG_ADDR_W = 5, REG_ZERO = 5'd0, default WIDTH 32.
  - Reused by the decode and hazard units.
- Sub-module rf_read_port:
  - Instantiated twice.
  - Generates WIDTH instances of the existing 32:1 bit mux, wiring bit b of each REG onto one mux's 32-bit input.
  - Applies the zero-register gating and the bypass compare.
- Top level contains storage, write decode, and reset logic.

Test Plan:
- Reset clears storage:
  - Stimulus: preload REG[5]=32'hDEADBEEF; assert RST one cycle with WE=1, WADDR=5, WDATA=32'h1234.
  - Required response: next cycle RADDR1=5 returns 32'h0; the write was discarded.
- Basic write/read:
  - Stimulus: WE=1, WADDR=17, WDATA=32'hA5A5_0F0F; one edge; then WE=0, RADDR1=17, RADDR2=16.
  - Required response: RDATA1=32'hA5A5_0F0F, RDATA2=32'h0.
- Zero register:
  - Stimulus: WE=1, WADDR=0, WDATA=32'hFFFF_FFFF with RADDR1=0 in the same cycle and after the edge.
  - Required response: RDATA1=0 both cycles.
- Bypass:
  - Stimulus: REG[9]=32'h1; WE=1, WADDR=9, WDATA=32'h2, RADDR1=9, RADDR2=9 before the edge.
  - Required response: both RDATA=32'h2 pre-edge; after the edge with WE=0 both RDATA still read 32'h2.
- Full sweep and boundary:
  - Stimulus: write REG[i]=i*32'h0101_0101 for i=1..31; read all pairs (i, 31-i).
  - Required response: every bit slice selects correctly, including indices 15/16 (the mux half boundary) and 31.
- Reset mid-stream:
  - Stimulus: back-to-back writes to 3 and 4, with RST asserted on the edge of the write to 4.
  - Required response: both REG[3] and REG[4] read 0 afterwards; bypass inactive during the RST cycle.

Source files
------------

// File: rtl/reg_file_2r1w_pkg.sv
// Shared register-file constants for the decode, hazard and regfile units.
// Index width and zero-register id are fixed by the ISA.
package reg_file_2r1w_pkg;
  localparam int REG_COUNT = 32;
  localparam int REG_ADDR_W = 5;
  localparam int DEF_WIDTH = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  function automatic logic is_zero_reg(
    input logic [REG_ADDR_W-1:0] a,
    input logic zr
  );
    return zr && (a == REG_ZERO);
  endfunction
endpackage

// File: rtl/reg_file_2r1w_read_port.sv
// Regfile read port: bit-sliced 32:1 muxes plus zero gating and
// same-cycle write-through bypass.
module bit_mux32 (
  input  logic [31:0] d,
  input  logic [4:0]  sel,
  output logic        y
);
  logic [15:0] dl;
  logic [15:0] dh;
  logic        lo;
  logic        hi;

  assign dl = d[15:0];
  assign dh = d[31:16];
  assign lo = dl[sel[3:0]];
  assign hi = dh[sel[3:0]];
  assign y  = sel[4] ? hi : lo;
endmodule

module rf_read_port
  import reg_file_2r1w_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int ZERO_REG = 1
) (
  input  logic [REG_COUNT-1:0][WIDTH-1:0] regs,
  input  logic [REG_ADDR_W-1:0]           raddr,
  input  logic                            rst,
  input  logic                            we,
  input  logic [REG_ADDR_W-1:0]           waddr,
  input  logic [WIDTH-1:0]                wdata,
  output logic [WIDTH-1:0]                rdata
);
  localparam logic ZR = (ZERO_REG != 0);

  logic [WIDTH-1:0] muxed;
  logic             zero_hit;
  logic             byp;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [REG_COUNT-1:0] slice;
    for (genvar r = 0; r < REG_COUNT; r++) begin : g_reg
      assign slice[r] = regs[r][b];
    end
    bit_mux32 u_mux (
      .d  (slice),
      .sel(raddr),
      .y  (muxed[b])
    );
  end

  assign zero_hit = is_zero_reg(raddr, ZR);
  // x0 writes never forward, so zero_hit and byp are exclusive
  assign byp = !rst && we && (waddr == raddr)
             && !is_zero_reg(waddr, ZR);

  always_comb begin
    rdata = muxed;
    unique case (1'b1)
      zero_hit: rdata = '0;
      byp:      rdata = wdata;
      default:  rdata = muxed;
    endcase
  end
endmodule

// File: rtl/reg_file_2r1w.sv
// 32 x WIDTH register file, two combinational read ports, one WB write
// port with synchronous reset and write-through bypass.
module reg_file_2r1w
  import reg_file_2r1w_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int ZERO_REG = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WE,
  input  logic [REG_ADDR_W-1:0] WADDR,
  input  logic [WIDTH-1:0]      WDATA,
  input  logic [REG_ADDR_W-1:0] RADDR1,
  input  logic [REG_ADDR_W-1:0] RADDR2,
  output logic [WIDTH-1:0]      RDATA1,
  output logic [WIDTH-1:0]      RDATA2
);
  localparam logic ZR = (ZERO_REG != 0);

  logic [REG_COUNT-1:0][WIDTH-1:0] regs;
  logic [REG_COUNT-1:0]            wdec;
  logic                            wr_ok;

  assign wr_ok = WE && !is_zero_reg(WADDR, ZR);

  always_comb begin
    wdec = '0;
    wdec[WADDR] = wr_ok;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      regs <= '0;
    end else begin
      for (int r = 0; r < REG_COUNT; r++) begin
        if (wdec[r]) regs[r] <= WDATA;
      end
    end
  end

  rf_read_port #(
    .WIDTH   (WIDTH),
    .ZERO_REG(ZERO_REG)
  ) u_rp1 (
    .regs (regs),
    .raddr(RADDR1),
    .rst  (RST),
    .we   (WE),
    .waddr(WADDR),
    .wdata(WDATA),
    .rdata(RDATA1)
  );

  rf_read_port #(
    .WIDTH   (WIDTH),
    .ZERO_REG(ZERO_REG)
  ) u_rp2 (
    .regs (regs),
    .raddr(RADDR2),
    .rst  (RST),
    .we   (WE),
    .waddr(WADDR),
    .wdata(WDATA),
    .rdata(RDATA2)
  );
endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: directed cases plus random traffic
// against an array model of the architectural registers.
module tb_reg_file_2r1w;
  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;

  int checks = 0;
  int errors = 0;
  logic [31:0] m [32];

  always #5 clk = ~clk;

  reg_file_2r1w #(
    .WIDTH   (32),
    .ZERO_REG(1)
  ) dut (
    .CLK   (clk),
    .RST   (rst),
    .WE    (we),
    .WADDR (waddr),
    .WDATA (wdata),
    .RADDR1(ra1),
    .RADDR2(ra2),
    .RDATA1(rd1),
    .RDATA2(rd2)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (!rst && we && waddr == a) return wdata;
    return m[a];
  endfunction

  task automatic tick();
    if (rst) begin
      for (int i = 0; i < 32; i++) m[i] = 32'h0;
    end else if (we && waddr != 5'd0) begin
      m[waddr] = wdata;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    ra1 = '0; ra2 = '0;
    #1;
    tick();
    tick();
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(31 - a);
      #1;
      chk("rst_rd1", rd1, 32'h0);
      chk("rst_rd2", rd2, 32'h0);
    end

    // reset discards a concurrent write
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0; ra1 = 5'd5;
    #1 chk("preload5", rd1, 32'hDEADBEEF);
    rst = 1'b1; we = 1'b1; waddr = 5'd5; wdata = 32'h1234;
    #1 chk("rst_nobyp", rd1, 32'hDEADBEEF);
    tick();
    rst = 1'b0; we = 1'b0;
    #1 chk("rst_clr5", rd1, 32'h0);

    // basic write/read
    we = 1'b1; waddr = 5'd17; wdata = 32'hA5A5_0F0F;
    tick();
    we = 1'b0; ra1 = 5'd17; ra2 = 5'd16;
    #1;
    chk("wr17", rd1, 32'hA5A5_0F0F);
    chk("rd16", rd2, 32'h0);

    // X address with write disabled
    waddr = 5'bx; wdata = 32'hFFFF_FFFF;
    tick();
    waddr = 5'd0;
    #1;
    chk("xaddr17", rd1, 32'hA5A5_0F0F);
    chk("xaddr16", rd2, 32'h0);

    // zero register
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; ra1 = 5'd0;
    #1 chk("zero_pre", rd1, 32'h0);
    tick();
    we = 1'b0;
    #1 chk("zero_post", rd1, 32'h0);

    // bypass on both ports
    we = 1'b1; waddr = 5'd9; wdata = 32'h1;
    tick();
    wdata = 32'h2; ra1 = 5'd9; ra2 = 5'd9;
    #1;
    chk("byp1_pre", rd1, 32'h2);
    chk("byp2_pre", rd2, 32'h2);
    tick();
    we = 1'b0;
    #1;
    chk("byp1_post", rd1, 32'h2);
    chk("byp2_post", rd2, 32'h2);

    // full sweep
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 32'(i) * 32'h0101_0101;
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #1;
      chk("sweep1", rd1, 32'(i) * 32'h0101_0101);
      chk("sweep2", rd2, 32'(31 - i) * 32'h0101_0101);
    end

    // reset mid-stream
    we = 1'b1; waddr = 5'd3; wdata = 32'h33;
    tick();
    rst = 1'b1; waddr = 5'd4; wdata = 32'h44;
    ra1 = 5'd4; ra2 = 5'd3;
    #1;
    chk("mid_nobyp4", rd1, 32'h0404_0404);
    chk("mid_reg3", rd2, 32'h33);
    tick();
    rst = 1'b0; we = 1'b0;
    #1;
    chk("mid_clr4", rd1, 32'h0);
    chk("mid_clr3", rd2, 32'h0);

    // random traffic against the model
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    for (int n = 0; n < 600; n++) begin
      rst   = ($urandom_range(0, 39) == 0);
      we    = 1'($urandom);
      waddr = 5'($urandom);
      wdata = $urandom;
      ra1   = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
      ra2   = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
      #1;
      chk("rnd_rd1", rd1, ref_rd(ra1));
      chk("rnd_rd2", rd2, ref_rd(ra2));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
